// File: rtl/tmr_reconfig_ctrl_if.sv
// Voter and DPR-engine signal bundle for tmr_reconfig_ctrl.
// master = replica/DPR-engine side, slave = the controller.
interface tmr_reconfig_ctrl_if;
  logic       rep_valid;
  logic [2:0] rep;
  logic       voted;
  logic       voted_valid;
  logic       uncorrectable;
  logic [2:0] mask;
  logic       dpr_req;
  logic [1:0] dpr_module;
  logic       dpr_ack;
  logic       dpr_done;
  logic       dpr_err;
  logic       busy;
  logic       fatal;

  modport master (
    output rep_valid, rep, dpr_ack, dpr_done, dpr_err,
    input  voted, voted_valid, uncorrectable, mask, dpr_req, dpr_module, busy, fatal
  );

  modport slave (
    input  rep_valid, rep, dpr_ack, dpr_done, dpr_err,
    output voted, voted_valid, uncorrectable, mask, dpr_req, dpr_module, busy, fatal
  );
endinterface

// File: rtl/tmr_reconfig_ctrl.sv
// TMR voter with leaky per-replica error counters and DPR repair sequencing.
// Vote has 1-cycle latency; no input backpressure, DPR side is req/ack then done.
module tmr_reconfig_ctrl #(
  parameter int ERR_W          = 4,
  parameter int ERR_THRESH     = 3,
  parameter int LEAK_PERIOD    = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 2,
  parameter int SETTLE_CYCLES  = 16
) (
  input logic                clk,
  input logic                rst_n,
  tmr_reconfig_ctrl_if.slave bus
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int LEAK_W  = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_DONE, S_SETTLE, S_FATAL
  } state_t;

  state_t             state_q, state_d;
  logic [ERR_W-1:0]   cnt_q [3];
  logic [LEAK_W-1:0]  leak_q;
  logic [TMR_W-1:0]   tmr_q, tmr_d, tmr_inc;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         module_q, module_d;
  logic               voted_q, voted_valid_q, unc_q;

  logic       maj, leak_tick, vote_ok, vote_val, pair_x, pair_y, timed_out;
  logic [2:0] mask, inc, dec, over;

  assign maj  = (bus.rep[0] & bus.rep[1]) | (bus.rep[0] & bus.rep[2]) | (bus.rep[1] & bus.rep[2]);
  assign mask = (state_q == S_IDLE) ? 3'b000 : (3'b001 << module_q);

  // The two replicas left in the vote when module_q is masked.
  always_comb begin
    pair_x = bus.rep[0];
    pair_y = bus.rep[1];
    case (module_q)
      2'd0:    begin pair_x = bus.rep[1]; pair_y = bus.rep[2]; end
      2'd1:    begin pair_x = bus.rep[0]; pair_y = bus.rep[2]; end
      default: begin pair_x = bus.rep[0]; pair_y = bus.rep[1]; end
    endcase
  end

  assign vote_ok  = (mask == 3'b000) ? 1'b1 : (pair_x == pair_y);
  assign vote_val = (mask == 3'b000) ? maj : (pair_x & pair_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voted_q       <= 1'b0;
      voted_valid_q <= 1'b0;
      unc_q         <= 1'b0;
    end else begin
      voted_valid_q <= bus.rep_valid;
      unc_q         <= bus.rep_valid & ~vote_ok;
      if (bus.rep_valid && vote_ok)
        voted_q <= vote_val;
    end
  end

  assign leak_tick = (leak_q == LEAK_W'(LEAK_PERIOD - 1));

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      inc[i]  = bus.rep_valid && (mask == 3'b000) && (bus.rep[i] != maj);
      dec[i]  = leak_tick && (cnt_q[i] != '0) && !mask[i];
      over[i] = (cnt_q[i] >= ERR_W'(ERR_THRESH));
    end
  end

  // A masked counter is held at zero, which also covers the clear on a successful repair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leak_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      leak_q <= leak_tick ? '0 : leak_q + 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (mask[i])
          cnt_q[i] <= '0;
        else if (inc[i] && !dec[i] && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec[i] && !inc[i])
          cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  assign tmr_inc   = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
  // Timer is 0 in the first REQ cycle, so this fires TIMEOUT_CYCLES cycles after REQ entry.
  assign timed_out = (tmr_q >= TMR_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    retry_d  = retry_q;
    module_d = module_q;
    case (state_q)
      S_IDLE: begin
        if (|over) begin
          state_d  = S_REQ;
          tmr_d    = '0;
          module_d = over[0] ? 2'd0 : (over[1] ? 2'd1 : 2'd2);
        end
      end
      S_REQ: begin
        tmr_d = tmr_inc;
        if (bus.dpr_ack) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        tmr_d = tmr_inc;
        if (bus.dpr_done && !bus.dpr_err) begin
          state_d = S_SETTLE;
          tmr_d   = '0;
        end else if ((bus.dpr_done && bus.dpr_err) || timed_out) begin
          if (retry_q < RETRY_W'(MAX_RETRY)) begin
            state_d = S_REQ;
            retry_d = retry_q + 1'b1;
            tmr_d   = '0;
          end else begin
            state_d = S_FATAL;
          end
        end
      end
      S_SETTLE: begin
        tmr_d = tmr_inc;
        if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
          state_d = S_IDLE;
          retry_d = '0;
          tmr_d   = '0;
        end
      end
      S_FATAL: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      retry_q  <= '0;
      module_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      retry_q  <= retry_d;
      module_q <= module_d;
    end
  end

  assign bus.voted         = voted_q;
  assign bus.voted_valid   = voted_valid_q;
  assign bus.uncorrectable = unc_q;
  assign bus.mask          = mask;
  assign bus.dpr_req       = (state_q == S_REQ);
  assign bus.dpr_module    = module_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.fatal         = (state_q == S_FATAL);

endmodule
